// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering an N:1 word mux into a registered valid/ready output stage.
// One word per cycle under continuous demand; gnt is combinational and marks consumption.
module rr_mux_arbiter #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 4,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  input  logic           out_ready
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_data;
  logic [SW-1:0] r_src;
  logic [SW-1:0] r_last;

  logic          w_any;
  logic [SW-1:0] w_winner;
  logic          w_load;
  logic          w_take;
  logic [W-1:0]  w_word;
  logic [W-1:0]  w_slot [N];

  for (genvar g = 0; g < N; g++) begin : g_slot
    assign w_slot[g] = in_data[g*W +: W];
  end

  assign w_word = w_slot[w_winner];

  // Cyclic scan starting just after the last winner.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned idx;
      idx = (32'(r_last) + k) % N;
      if (!w_any && req[SW'(idx)]) begin
        w_any    = 1'b1;
        w_winner = SW'(idx);
      end
    end
  end

  // Next-state and grant: a word is taken only when the stage is empty or emptying.
  always_comb begin
    w_state_nxt = r_state;
    gnt         = '0;
    w_load      = (r_state == IDLE) || out_ready;
    w_take      = rst_n && w_load && w_any;
    if (w_take) begin
      gnt[w_winner] = 1'b1;
    end
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = BUSY;
      BUSY:    if (out_ready && !w_any) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_src   <= '0;
      r_last  <= SW'(N - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_data <= w_word;
        r_src  <= w_winner;
        r_last <= w_winner;
      end
    end
  end

  assign out_valid = (r_state == BUSY);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=4) with hand-computed expectations.
module tb_rr_mux_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  int tests = 0;
  int fails = 0;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".src"},   32'(out_src),   32'(s));
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    in_data   = {4'h8, 4'h7, 4'h3, 4'h5};
    tick();
    tick();
    rst_n = 1'b1;

    // 1: load a word, stall, then reset discards it
    req = 4'b0010;
    #1 chk("t1.gnt_idle", 32'(gnt), 32'b0010);
    tick();
    chk_out("t1.loaded", 1'b1, 4'h3, 2'd1);
    rst_n = 1'b0;
    req   = 4'b1111;
    #1 chk("t1.gnt_in_reset", 32'(gnt), 32'b0000);
    tick();
    chk_out("t1.after_rst", 1'b0, 4'h0, 2'd0);
    chk("t1.gnt_in_reset2", 32'(gnt), 32'b0000);
    rst_n   = 1'b1;
    in_data = {4'h8, 4'h7, 4'h6, 4'h5};
    #1 chk("t1.first_gnt", 32'(gnt), 32'b0001);
    tick();
    chk_out("t1.first", 1'b1, 4'h5, 2'd0);

    // 3: rotation under continuous demand
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] e;
      e = 2'(k % 4);
      #1 chk("t3.gnt", 32'(gnt), 32'(4'b0001 << e));
      tick();
      chk_out("t3.out", 1'b1, 4'(5 + e), e);
    end

    // 4: backpressure holds the word and blocks grants
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4.gnt_stall", 32'(gnt), 32'b0000);
      tick();
      chk_out("t4.hold", 1'b1, 4'h5, 2'd0);
    end
    out_ready = 1'b1;
    #1 chk("t4.gnt_resume", 32'(gnt), 32'b0010);
    tick();
    chk_out("t4.resume", 1'b1, 4'h6, 2'd1);

    // 5: reach a grant to 3, then sparse requests skip empty slots
    #1 chk("t5.gnt2", 32'(gnt), 32'b0100);
    tick();
    #1 chk("t5.gnt3", 32'(gnt), 32'b1000);
    tick();
    chk_out("t5.at3", 1'b1, 4'h8, 2'd3);
    req = 4'b1010;
    #1 chk("t5.wrap1", 32'(gnt), 32'b0010);
    tick();
    chk_out("t5.s1", 1'b1, 4'h6, 2'd1);
    #1 chk("t5.skip3", 32'(gnt), 32'b1000);
    tick();
    chk_out("t5.s3", 1'b1, 4'h8, 2'd3);
    #1 chk("t5.again1", 32'(gnt), 32'b0010);
    tick();
    chk_out("t5.s1b", 1'b1, 4'h6, 2'd1);

    // 6: drain to IDLE, out_ready ignored while idle, then re-arm
    req = 4'b0000;
    #1 chk("t6.gnt_none", 32'(gnt), 32'b0000);
    tick();
    chk("t6.drained", 32'(out_valid), 32'd0);
    tick();
    chk("t6.still_idle", 32'(out_valid), 32'd0);
    req     = 4'b0001;
    in_data = {4'h8, 4'hA, 4'h6, 4'hC};
    #1 chk("t6.gnt0", 32'(gnt), 32'b0001);
    tick();
    chk_out("t6.rearm", 1'b1, 4'hC, 2'd0);

    // 2: single request, last=0 so slot 2 wins immediately
    req = 4'b0100;
    #1 chk("t2.gnt", 32'(gnt), 32'b0100);
    tick();
    chk_out("t2.out", 1'b1, 4'hA, 2'd2);

    req = 4'b0000;
    tick();
    chk("t2.drain", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
